// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: FIFO of dirty-line writes toward the AXI bridge, with
// read-after-write hazard detection against every buffered line.
// Optional feature macro: WB_FORWARD_EN (forward youngest matching line data).
module dcache_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int LINE_LSB = 6
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [31:0]  c_waddr,
    input  logic [511:0] c_wdata,
    input  logic [7:0]   c_wlen,
    input  logic [2:0]   c_wsize,
    input  logic [3:0]   c_wstrb,
    input  logic         c_wvalid,
    output logic         c_wready,
    output logic [31:0]  d_waddr,
    output logic [511:0] d_wdata,
    output logic [7:0]   d_wlen,
    output logic [2:0]   d_wsize,
    output logic [3:0]   d_wstrb,
    output logic         d_wvalid,
    input  logic         d_wready,
    input  logic [31:0]  r_addr,
    output logic         raw_hit,
    output logic [511:0] raw_data,
    output logic         wb_empty
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state, state_nx;
    logic [31:0]   addr_q [DEPTH];
    logic [511:0]  data_q [DEPTH];
    logic [7:0]    len_q  [DEPTH];
    logic [2:0]    size_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, idx, sel;
    logic [AW:0]   count;
    logic          push, pop, send;
    logic          unused_low;

    assign unused_low = ^r_addr[LINE_LSB-1:0];
    assign send       = (state == SEND);
    assign c_wready   = (count != (AW+1)'(DEPTH));
    assign push       = c_wvalid && c_wready;
    assign pop        = send && d_wready;
    assign wb_empty   = (count == '0) && !send;

    // FSM, pointers and occupancy; reset discards everything including the in-flight write
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Entry storage; stale contents are masked by count so no reset is needed
    always_ff @(posedge aclk) begin
        if (push) begin
            addr_q[wr_ptr] <= c_waddr;
            data_q[wr_ptr] <= c_wdata;
            len_q[wr_ptr]  <= c_wlen;
            size_q[wr_ptr] <= c_wsize;
            strb_q[wr_ptr] <= c_wstrb;
        end
    end

    // Issue sequencing: present head once the buffer is non-empty after this edge,
    // and always insert one idle cycle after each completed write
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (push || count != '0) ? SEND : IDLE;
            SEND:    state_nx = d_wready ? GAP : SEND;
            GAP:     state_nx = (push || count != '0) ? SEND : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Head presentation; fields read as zero whenever no write is offered
    always_comb begin
        d_wvalid = send;
        d_waddr  = send ? addr_q[rd_ptr] : '0;
        d_wdata  = send ? data_q[rd_ptr] : '0;
        d_wlen   = send ? len_q[rd_ptr]  : '0;
        d_wsize  = send ? size_q[rd_ptr] : '0;
        d_wstrb  = send ? strb_q[rd_ptr] : '0;
    end

    // Hazard scan from oldest to youngest so the last match is the youngest
    always_comb begin
        raw_hit = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + AW'(k);
            if ((AW+1)'(k) < count && addr_q[idx][31:LINE_LSB] == r_addr[31:LINE_LSB]) begin
                raw_hit = 1'b1;
                sel     = idx;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign raw_data = raw_hit ? data_q[sel] : '0;
`else
    logic unused_sel;
    assign unused_sel = ^sel;
    assign raw_data   = '0;
`endif
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed plus randomized checks against a queue-based model.
module tb_dcache_write_buffer;
    localparam int DEPTH = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  c_waddr;
    logic [511:0] c_wdata;
    logic [7:0]   c_wlen;
    logic [2:0]   c_wsize;
    logic [3:0]   c_wstrb;
    logic         c_wvalid;
    logic         c_wready;
    logic [31:0]  d_waddr;
    logic [511:0] d_wdata;
    logic [7:0]   d_wlen;
    logic [2:0]   d_wsize;
    logic [3:0]   d_wstrb;
    logic         d_wvalid;
    logic         d_wready;
    logic [31:0]  r_addr;
    logic         raw_hit;
    logic [511:0] raw_data;
    logic         wb_empty;

    dcache_write_buffer #(.DEPTH(DEPTH), .LINE_LSB(6)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wlen(c_wlen), .c_wsize(c_wsize),
        .c_wstrb(c_wstrb), .c_wvalid(c_wvalid), .c_wready(c_wready),
        .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wlen(d_wlen), .d_wsize(d_wsize),
        .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
        .r_addr(r_addr), .raw_hit(raw_hit), .raw_data(raw_data), .wb_empty(wb_empty)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]  a;
        logic [511:0] d;
        logic [7:0]   l;
        logic [2:0]   s;
        logic [3:0]   w;
    } ent_t;

    ent_t q[$];
    bit   m_send;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic         hit = 1'b0;
        logic [511:0] fwd = '0;
        foreach (q[i]) if (q[i].a[31:6] == r_addr[31:6]) begin hit = 1'b1; fwd = q[i].d; end
`ifndef WB_FORWARD_EN
        fwd = '0;
`endif
        chk({tag, ".d_wvalid"}, d_wvalid, m_send);
        chk({tag, ".d_waddr"}, d_waddr, m_send ? q[0].a : 32'h0);
        chk({tag, ".d_wdata"}, d_wdata, m_send ? q[0].d : 512'h0);
        chk({tag, ".d_wlen"}, d_wlen, m_send ? q[0].l : 8'h0);
        chk({tag, ".d_wsize"}, d_wsize, m_send ? q[0].s : 3'h0);
        chk({tag, ".d_wstrb"}, d_wstrb, m_send ? q[0].w : 4'h0);
        chk({tag, ".c_wready"}, c_wready, q.size() < DEPTH);
        chk({tag, ".wb_empty"}, wb_empty, q.size() == 0 && !m_send);
        chk({tag, ".raw_hit"}, raw_hit, hit);
        chk({tag, ".raw_data"}, raw_data, fwd);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [511:0] d, input logic rdy);
        c_wvalid = v;
        c_waddr  = a;
        c_wdata  = d;
        c_wlen   = 8'($urandom());
        c_wsize  = 3'($urandom());
        c_wstrb  = 4'($urandom());
        d_wready = rdy;
    endtask

    task automatic tick(input string tag);
        bit do_push = c_wvalid && (q.size() < DEPTH);
        bit do_pop  = m_send && d_wready;
        ent_t e;
        e = '{a: c_waddr, d: c_wdata, l: c_wlen, s: c_wsize, w: c_wstrb};
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        m_send = m_send ? !d_wready : (q.size() > 0);
        @(posedge aclk);
        #1;
        check_outputs(tag);
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 512'h0, 1'b1);
        repeat (12) tick("drain");
        d_wready = 1'b0;
    endtask

    initial begin
        logic [511:0] da, db;
        aresetn = 1'b0;
        r_addr  = 32'h0;
        drive(1'b0, 32'h0, 512'h0, 1'b0);
        q.delete();
        m_send = 0;
        repeat (3) @(posedge aclk);
        #1;
        check_outputs("reset");
        aresetn = 1'b1;

        drive(1'b1, 32'h1C000040, rnd512(), 1'b0);
        tick("sw_push");
        chk("sw_latency", d_wvalid, 1'b1);
        chk("sw_addr", d_waddr, 32'h1C000040);
        drive(1'b0, 32'h0, 512'h0, 1'b0);
        repeat (2) tick("sw_hold");
        d_wready = 1'b1;
        tick("sw_pop");
        chk("sw_gap", d_wvalid, 1'b0);
        tick("ign_rdy");
        d_wready = 1'b0;
        tick("sw_idle");
        chk("sw_empty", wb_empty, 1'b1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2000 + 32'(i * 64), rnd512(), 1'b0);
            tick("fill");
        end
        chk("fill_full", c_wready, 1'b0);
        drive(1'b1, 32'h3000, rnd512(), 1'b0);
        tick("fill_5th");
        drain();
        chk("fill_done", wb_empty, 1'b1);

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h4000 + 32'(i * 64), rnd512(), 1'b0);
            tick("pp_pre");
        end
        drive(1'b1, 32'h4100, rnd512(), 1'b1);
        tick("pp_both");
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h4200 + 32'(i * 64), rnd512(), 1'b0);
            tick("pp_fill");
        end
        chk("pp_full", c_wready, 1'b0);
        drive(1'b1, 32'h4F00, rnd512(), 1'b1);
        tick("pp_fullpop");
        chk("pp_after", c_wready, 1'b1);
        drain();

        da = rnd512();
        db = rnd512();
        drive(1'b1, 32'h1000, da, 1'b0);
        tick("raw_a");
        drive(1'b1, 32'h1000, db, 1'b0);
        tick("raw_b");
        drive(1'b0, 32'h0, 512'h0, 1'b0);
        r_addr = 32'h1024;
        #1;
        check_outputs("raw_hit");
        chk("raw_hit_k", raw_hit, 1'b1);
`ifdef WB_FORWARD_EN
        chk("raw_data_b", raw_data, db);
`else
        chk("raw_data_0", raw_data, 512'h0);
`endif
        r_addr = 32'h1040;
        #1;
        chk("raw_miss", raw_hit, 1'b0);
        r_addr = 32'h5000;
        drive(1'b1, 32'h5008, rnd512(), 1'b0);
        #1;
        chk("raw_pre", raw_hit, 1'b0);
        tick("raw_post");
        chk("raw_post_k", raw_hit, 1'b1);
        drain();

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1) == 1, 32'h1000 + 32'($urandom_range(0, 3) * 64) + 32'($urandom_range(0, 63)),
                  rnd512(), $urandom_range(0, 2) == 0);
            r_addr = 32'h1000 + 32'($urandom_range(0, 4) * 64) + 32'($urandom_range(0, 63));
            tick("rand");
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h6000 + 32'(i * 64), rnd512(), 1'b0);
            tick("mr_fill");
        end
        drive(1'b0, 32'h0, 512'h0, 1'b0);
        r_addr = 32'h6000;
        #2;
        chk("mr_send", d_wvalid, 1'b1);
        aresetn = 1'b0;
        q.delete();
        m_send = 0;
        #1;
        check_outputs("mr_async");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) tick("mr_noreplay");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queued write entries (power of two, 2..8).
REQ-002 The block SHALL have parameter LINE_LSB, default 6, giving the low bit of the line-address compare field [31:LINE_LSB].
REQ-003 The block SHALL have port aclk, input, 1, the single clock.
REQ-004 The block SHALL have port aresetn, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have cache-side inputs c_waddr[31:0], c_wdata[511:0], c_wlen[7:0], c_wsize[2:0] and c_wstrb[3:0], carrying the write request fields.
REQ-006 The block SHALL have port c_wvalid, input, 1, indicating that a cache write request is offered.
REQ-007 The block SHALL have port c_wready, output, 1, indicating that the buffer can accept an entry.
REQ-008 The block SHALL have bridge-side outputs d_waddr[31:0], d_wdata[511:0], d_wlen[7:0], d_wsize[2:0] and d_wstrb[3:0], carrying the head entry.
REQ-009 The block SHALL have port d_wvalid, output, 1, indicating that the head entry is presented to the AXI bridge.
REQ-010 The block SHALL have port d_wready, input, 1, a one-cycle pulse from the AXI bridge on B-response completion.
REQ-011 The block SHALL have port r_addr, input, 32, the cache read-miss address to be hazard-checked.
REQ-012 The block SHALL have port raw_hit, output, 1, asserted when r_addr matches a buffered line.
REQ-013 The block SHALL have port raw_data, output, 512, the forwarded line data.
REQ-014 The block SHALL have port wb_empty, output, 1, asserted when no entry is queued or in flight.

Function
REQ-015 A push SHALL occur on the cycle c_wvalid&c_wready is high, capturing all c_w* fields into the tail entry.
REQ-016 c_wready SHALL equal !full, derived from registered state only, so a pop does not enable a push in the same cycle.
REQ-017 Issue control SHALL be a three-state FSM: IDLE (no entry presented), SEND (d_wvalid=1, head fields driven), GAP (d_wvalid=0 for one cycle).
REQ-018 The FSM SHALL move IDLE->SEND on the cycle after the count becomes nonzero; latency from a push into an empty buffer to d_wvalid SHALL be exactly 1 cycle.
REQ-019 In SEND, the d_w* outputs SHALL hold stable until d_wready; on d_wready the head SHALL pop and the FSM SHALL go to GAP.
REQ-020 GAP SHALL return to SEND if entries remain, otherwise to IDLE, guaranteeing the bridge sees d_wvalid low for at least one cycle between writes.
REQ-021 d_wready received outside SEND SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-023 In IDLE and GAP, d_w* outputs SHALL be 0.
REQ-024 raw_hit SHALL be combinational: 1 if any valid entry, including the in-flight head, has addr[31:LINE_LSB]==r_addr[31:LINE_LSB].
REQ-025 On multiple matches, the youngest matching entry SHALL be selected.
REQ-026 A push in the current cycle SHALL NOT be visible to raw_hit until the next cycle.
REQ-027 wb_empty SHALL be 1 when count==0 and the FSM is in IDLE or GAP.

Reset
REQ-028 On aresetn low, the FSM SHALL asynchronously enter IDLE and the count and pointers SHALL clear.
REQ-029 Under reset, outputs SHALL be: d_wvalid=0, c_wready=1, raw_hit=0, wb_empty=1, and all data/address outputs 0.
REQ-030 Reset mid-transaction SHALL discard all entries, including the in-flight write, with no replay.

Configuration
REQ-031 With macro WB_FORWARD_EN defined, raw_data SHALL carry the youngest matching entry's data whenever raw_hit=1, and SHALL be 0 otherwise.
REQ-032 Without WB_FORWARD_EN, raw_data SHALL be tied to 0, no data-select logic SHALL exist, and the cache SHALL stall while raw_hit=1.

Verification
REQ-033 The bench SHALL cover a single write: push addr 0x1C000040 into an empty buffer, with d_wvalid=1 one cycle later; d_wready pulse -> one GAP cycle, then IDLE, wb_empty=1.
REQ-034 The bench SHALL cover fill: push 4 entries with no d_wready -> c_wready=0 after the 4th; a 5th offer is not accepted; entries drain in FIFO order with a one-cycle gap between them.
REQ-035 The bench SHALL cover push and pop together: with count=2, a push in the same cycle as d_wready -> count stays 2, and a full-buffer pop does not allow a same-cycle push.
REQ-036 The bench SHALL cover a RAW hit: entries at 0x1000 and 0x1000 (data A then B), r_addr=0x1024 -> raw_hit=1 and raw_data=B with WB_FORWARD_EN; with r_addr=0x1040, raw_hit=0.
REQ-037 The bench SHALL cover mid-operation reset: aresetn asserted in SEND with 3 entries -> d_wvalid=0 immediately, c_wready=1, and wb_empty=1.
